// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared CDB widths, tag constants and broadcast record type
// Purpose: common definitions for the arbiter and for CDB consumers
//          (register file, reservation stations).
// Contents: NUM_UNITS, DATA_W, TAG_W, NO_TAG, cdb_t {valid, tag, data}.
package cdb_pkg;

  localparam int NUM_UNITS = 8;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = $clog2(NUM_UNITS);

  // Tag 0 means "no producer"; real units are 1..NUM_UNITS-1.
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

endpackage

// File: rtl/cdb_rr_pick.sv
// rtl/cdb_rr_pick.sv - combinational round-robin picker over units 1..NUM_UNITS-1
// Purpose: choose one requester, searching from rr_ptr+1 upward and wrapping
//          from NUM_UNITS-1 back to 1 (unit 0 is never a candidate).
// Ports:
//   req    in  NUM_UNITS  request vector (bit 0 ignored)
//   rr_ptr in  TAG_W      last granted unit
//   grant  out NUM_UNITS  one-hot grant (all zero when nothing requests)
//   idx    out TAG_W      index of the granted unit
//   any    out 1          a grant was made
module cdb_rr_pick
  import cdb_pkg::*;
(
  input  logic [NUM_UNITS-1:0] req,
  input  logic [TAG_W-1:0]     rr_ptr,
  output logic [NUM_UNITS-1:0] grant,
  output logic [TAG_W-1:0]     idx,
  output logic                 any
);

  logic [TAG_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = NO_TAG;
    any   = 1'b0;
    cand  = NO_TAG;
    for (int k = 1; k < NUM_UNITS; k++) begin
      // Position k in the search order, mapped onto the ring 1..NUM_UNITS-1.
      cand = TAG_W'(((int'(rr_ptr) - 1 + k) % (NUM_UNITS - 1)) + 1);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with per-unit holding slots
// Purpose: each functional unit 1..NUM_UNITS-1 owns a one-entry slot; one
//          result per cycle is broadcast on the registered CDB.
// Ports:
//   CLOCK_50  in  1                  clock, rising edge
//   RSTN_N    in  1                  asynchronous active-low reset
//   flush     in  1                  discard all buffered and pending results
//   fu_valid  in  NUM_UNITS          unit i presents a result (bit 0 ignored)
//   fu_data   in  NUM_UNITS*DATA_W   result of unit i in slice i
//   fu_ready  out NUM_UNITS          unit i's result accepted this cycle
//   cdb_valid out 1                  registered broadcast valid
//   cdb_tag   out TAG_W              registered producing unit
//   cdb_data  out DATA_W             registered broadcast value
// Option: CDB_BYPASS_EN lets an empty-slot unit with fu_valid compete in the
//         same cycle and go straight to the CDB registers.
module cdb_arbiter
  import cdb_pkg::*;
(
  input  logic                        CLOCK_50,
  input  logic                        RSTN_N,
  input  logic                        flush,
  input  logic [NUM_UNITS-1:0]        fu_valid,
  input  logic [NUM_UNITS*DATA_W-1:0] fu_data,
  output logic [NUM_UNITS-1:0]        fu_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data
);

  logic [NUM_UNITS-1:0] slot_full_q, slot_full_d;
  logic [DATA_W-1:0]    slot_data_q [NUM_UNITS];
  logic [DATA_W-1:0]    slot_data_d [NUM_UNITS];
  logic [TAG_W-1:0]     rr_ptr_q, rr_ptr_d;
  cdb_t                 cdb_q, cdb_d;

  logic [DATA_W-1:0]    fu_slice [NUM_UNITS];
  logic [NUM_UNITS-1:0] req, bypass, grant;
  logic [TAG_W-1:0]     pick_idx;
  logic                 pick_any;

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      fu_slice[i] = fu_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    bypass = '0;
`ifdef CDB_BYPASS_EN
    bypass = fu_valid & ~slot_full_q;
`endif
    bypass[0] = 1'b0;
    req       = slot_full_q | bypass;
    req[0]    = 1'b0;
    // Flush dominates: no grant, so nothing leaves a slot or reaches the CDB.
    if (flush) begin
      req = '0;
    end
  end

  cdb_rr_pick u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_d       = '0;
    fu_ready    = '0;

    // A granted slot drains this edge, so it can take a new result in the
    // same cycle without a bubble.
    for (int i = 1; i < NUM_UNITS; i++) begin
      fu_ready[i] = !flush && (!slot_full_q[i] || grant[i]);
    end

    if (flush) begin
      slot_full_d = '0;
    end else begin
      if (pick_any) begin
        rr_ptr_d   = pick_idx;
        cdb_d.valid = 1'b1;
        cdb_d.tag   = pick_idx;
        // An empty winner can only be a bypass candidate.
        cdb_d.data  = slot_full_q[pick_idx] ? slot_data_q[pick_idx]
                                            : fu_slice[pick_idx];
      end
      for (int i = 1; i < NUM_UNITS; i++) begin
        if (grant[i]) begin
          slot_full_d[i] = 1'b0;
        end
        // A bypassed result goes to the CDB only, never into the slot.
        if (fu_valid[i] && fu_ready[i] && !(grant[i] && bypass[i])) begin
          slot_full_d[i] = 1'b1;
          slot_data_d[i] = fu_slice[i];
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      slot_full_q <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        slot_data_q[i] <= '0;
      end
      // Start just below unit 1 so unit 1 has first priority.
      rr_ptr_q <= TAG_W'(NUM_UNITS - 1);
      cdb_q    <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_data_q <= slot_data_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_q       <= cdb_d;
    end
  end

  assign cdb_valid = cdb_q.valid;
  assign cdb_tag   = cdb_q.tag;
  assign cdb_data  = cdb_q.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter (CDB_BYPASS_EN aware)
module tb_cdb_arbiter;
  import cdb_pkg::*;

`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                        CLOCK_50 = 1'b0;
  logic                        RSTN_N   = 1'b0;
  logic                        flush    = 1'b0;
  logic [NUM_UNITS-1:0]        fu_valid = '0;
  logic [NUM_UNITS*DATA_W-1:0] fu_data  = '0;
  logic [NUM_UNITS-1:0]        fu_ready;
  logic                        cdb_valid;
  logic [TAG_W-1:0]            cdb_tag;
  logic [DATA_W-1:0]           cdb_data;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  cdb_arbiter dut (
    .CLOCK_50  (CLOCK_50),
    .RSTN_N    (RSTN_N),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_data   (fu_data),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1_000_000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and score any broadcast.
  task automatic tick();
    exp_t e;
    @(posedge CLOCK_50);
    #1;
    if (cdb_valid === 1'b1) begin
      check("bcast_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("bcast_tag", 64'(cdb_tag), 64'(e.tag));
        check("bcast_data", 64'(cdb_data), 64'(e.data));
      end
    end
  endtask

  task automatic set_unit(input int u, input logic [DATA_W-1:0] d);
    fu_valid[u] = 1'b1;
    fu_data[u*DATA_W +: DATA_W] = d;
  endtask

  task automatic drive(input int u, input logic [DATA_W-1:0] d);
    exp_t e;
    set_unit(u, d);
    e.tag  = TAG_W'(u);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic idle();
    fu_valid = '0;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
    check("sb_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    RSTN_N = 1'b0;
    idle();
    flush = 1'b0;
    sb.delete();
    #1;
    check("rst_valid", 64'(cdb_valid), 64'(0));
    check("rst_tag", 64'(cdb_tag), 64'(0));
    check("rst_data", 64'(cdb_data), 64'(0));
    @(negedge CLOCK_50);
    RSTN_N = 1'b1;
    #1;
    check("rst_ready", 64'(fu_ready), 64'(8'hFE));
  endtask

  initial begin
    // Reset state, then unit 5 0xABCD: latency 2 cycles (1 with bypass).
    do_reset();
    drive(5, 32'h0000_ABCD);
    tick();
    idle();
    if (!BYP) begin
      check("lat_c1_idle", 64'(cdb_valid), 64'(0));
      tick();
    end
    check("lat_valid", 64'(cdb_valid), 64'(1));
    tick();
    check("single_pulse_a", 64'(cdb_valid), 64'(0));

    // Unit 3 data 5.
    do_reset();
    drive(3, 32'h0000_0005);
    tick();
    idle();
    if (!BYP) begin
      check("u3_c1_idle", 64'(cdb_valid), 64'(0));
      tick();
    end
    check("u3_valid", 64'(cdb_valid), 64'(1));
    tick();
    check("single_pulse_b", 64'(cdb_valid), 64'(0));
    drain(2);

    // Units 1,2,5 in one cycle: all ready, broadcast 1,2,5.
    do_reset();
    drive(1, 32'h11);
    drive(2, 32'h22);
    drive(5, 32'h55);
    #1;
    check("multi_ready", 64'(fu_ready), 64'(8'hFE));
    tick();
    idle();
    drain(5);

    // Grant unit 6 to set rr_ptr=6, then units 7 and 1 together: 7 before 1.
    do_reset();
    drive(6, 32'h66);
    tick();
    idle();
    drain(3);
    drive(7, 32'h77);
    drive(1, 32'h1111);
    tick();
    idle();
    drain(4);

    // All units at once: starvation bound, order 1..7.
    do_reset();
    for (int u = 1; u < NUM_UNITS; u++) drive(u, 32'hA000 + u);
    tick();
    idle();
    drain(NUM_UNITS + 1);

    // Unit 4 streaming: one broadcast per cycle, fu_ready[4] stays high.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(4, 32'h100 + k);
      #1;
      check("stream_ready", 64'(fu_ready[4]), 64'(1));
      tick();
      if (k >= (BYP ? 0 : 1)) check("stream_valid", 64'(cdb_valid), 64'(1));
    end
    idle();
    drain(3);

    // Slots 2 and 6 filled, then flush: no later broadcast of them.
    do_reset();
    set_unit(2, 32'h2222);
    set_unit(6, 32'h6666);
    if (BYP) begin
      sb.push_back('{tag: TAG_W'(2), data: 32'h2222});
    end
    tick();
    idle();
    flush = 1'b1;
    set_unit(3, 32'h3333);
    #1;
    check("flush_ready", 64'(fu_ready), 64'(0));
    tick();
    idle();
    flush = 1'b0;
    check("flush_valid", 64'(cdb_valid), 64'(0));
    drain(6);

    // Reset mid-burst: outputs drop immediately, buffered results discarded.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(4, 32'h200 + k);
      tick();
    end
    #2;
    RSTN_N = 1'b0;
    #1;
    check("arst_valid", 64'(cdb_valid), 64'(0));
    check("arst_tag", 64'(cdb_tag), 64'(0));
    check("arst_data", 64'(cdb_data), 64'(0));
    idle();
    sb.delete();
    @(negedge CLOCK_50);
    RSTN_N = 1'b1;
    #1;
    check("arst_ready", 64'(fu_ready), 64'(8'hFE));
    drain(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
